// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a valid/ready operand handshake and a
// valid/ready result handshake. Single-cycle ops pass IDLE -> EXEC -> DONE.
// Optional feature macro SEQ_ALU_MUL_EN: when defined, op 7 is an unsigned
// iterative shift-add multiply through a MUL state (WIDTH iterations); when
// undefined, op 7 goes through EXEC and returns the illegal-op marker
// (out=0, overflow=1, zero=1).
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. in_ready is high only in IDLE, out_valid is
// high only in DONE, and out/flags are held stable for the whole of DONE.
module seq_alu #(
    parameter int WIDTH = 12,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op_select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             sign,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Elaboration guard: narrow widths and overridden counter widths are not supported.
    if (WIDTH < 4 || CNT_W != $clog2(WIDTH+1)) begin : g_bad_param
        $error("seq_alu: WIDTH must be >= 4 and CNT_W must not be overridden");
    end

`ifdef SEQ_ALU_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
`endif

    // state is the FSM observation point for checkers
    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [2:0]       op_r;
    logic             accept;

    logic [WIDTH-1:0] exec_out;
    logic             exec_cout;
    logic             exec_ovf;
    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;

    assign accept    = (state == S_IDLE) && in_valid;
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

`ifdef SEQ_ALU_MUL_EN
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_next;
    logic               mul_last;

    assign mul_last = (cnt == CNT_W'(WIDTH-1));

    // Partial product for the current multiplier bit.
    always_comb begin
        prod_next = prod + (mplier[0] ? mcand : '0);
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
`ifdef SEQ_ALU_MUL_EN
                    state_next = (op_select == 3'd7) ? S_MUL : S_EXEC;
`else
                    state_next = S_EXEC;
`endif
                end
            end
            S_EXEC: state_next = S_DONE;
`ifdef SEQ_ALU_MUL_EN
            S_MUL:  if (mul_last) state_next = S_DONE;
`endif
            S_DONE: if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Single-cycle operation results from the latched operands.
    always_comb begin
        exec_out  = '0;
        exec_cout = 1'b0;
        exec_ovf  = 1'b0;
        sum_add   = {1'b0, a_r} + {1'b0, b_r};
        sum_sub   = {1'b0, a_r} + {1'b0, ~b_r} + {{WIDTH{1'b0}}, 1'b1};
        case (op_r)
            3'd0: begin
                exec_out = a_r[WIDTH-1] ? (~a_r + WIDTH'(1)) : a_r;
                exec_ovf = (a_r == MIN_NEG);
            end
            3'd1: begin
                {exec_cout, exec_out} = sum_add;
                exec_ovf = (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                           (sum_add[WIDTH-1] != a_r[WIDTH-1]);
            end
            3'd2: exec_out = a_r & b_r;
            3'd3: exec_out = a_r | b_r;
            3'd4: exec_out = a_r ^ b_r;
            3'd5: exec_out = ~a_r;
            3'd6: begin
                {exec_cout, exec_out} = sum_sub;
                exec_ovf = (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                           (sum_sub[WIDTH-1] != a_r[WIDTH-1]);
            end
            default: begin
                // op 7 in EXEC: illegal-op marker
                exec_out = '0;
                exec_ovf = 1'b1;
            end
        endcase
    end

    // Operand latch, multiply iteration and result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= '0;
            out      <= '0;
            cout     <= 1'b0;
            sign     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            prod     <= '0;
`endif
        end else begin
            if (accept) begin
                a_r  <= a;
                b_r  <= b;
                op_r <= op_select;
`ifdef SEQ_ALU_MUL_EN
                cnt    <= '0;
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                prod   <= '0;
`endif
            end
            if (state == S_EXEC) begin
                out      <= exec_out;
                cout     <= exec_cout;
                overflow <= exec_ovf;
                sign     <= exec_out[WIDTH-1];
                zero     <= (exec_out == '0);
            end
`ifdef SEQ_ALU_MUL_EN
            if (state == S_MUL) begin
                prod   <= prod_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
                if (mul_last) begin
                    out      <= prod_next[WIDTH-1:0];
                    cout     <= 1'b0;
                    overflow <= (prod_next[2*WIDTH-1:WIDTH] != '0);
                    sign     <= prod_next[WIDTH-1];
                    zero     <= (prod_next[WIDTH-1:0] == '0);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vector table plus hand-written sequences for
// backpressure and mid-operation reset. Build with +define+SEQ_ALU_MUL_EN
// to cover the multiply path; otherwise op 7 is checked as illegal.
module tb_seq_alu;

    localparam int W = 12;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op_select;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         cout;
    logic         sign;
    logic         overflow;
    logic         zero;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] out;
        logic         cout;
        logic         ovf;
        logic         sign;
        logic         zero;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op_select(op_select),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .cout(cout), .sign(sign), .overflow(overflow),
        .zero(zero), .busy(busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic [2:0] vop, input logic [W-1:0] vout,
                                input logic vc, input logic vo, input logic vs,
                                input logic vz, input int vl);
        vec_t v;
        v.a = va; v.b = vb; v.op = vop; v.out = vout;
        v.cout = vc; v.ovf = vo; v.sign = vs; v.zero = vz; v.lat = vl;
        return v;
    endfunction

    // driver: present one operation in IDLE; returns after the accept edge (+#1)
    task automatic issue(input vec_t v, input string tag);
        chk({tag, " in_ready before issue"}, 32'(in_ready), 32'd1);
        a = v.a; b = v.b; op_select = v.op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom_range(0, (1 << W) - 1);
        b = $urandom_range(0, (1 << W) - 1);
        exp_q.push_back(v.out);
    endtask

    // bounded wait for out_valid; edges counts the accept edge as 1
    task automatic wait_out(output int edges);
        edges = 1;
        while (out_valid !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic check_result(input vec_t v, input int edges, input string tag);
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " latency"},   32'(edges),     32'(v.lat));
        chk({tag, " out"},       32'(out),       32'(e));
        chk({tag, " cout"},      32'(cout),      32'(v.cout));
        chk({tag, " overflow"},  32'(overflow),  32'(v.ovf));
        chk({tag, " sign"},      32'(sign),      32'(v.sign));
        chk({tag, " zero"},      32'(zero),      32'(v.zero));
        chk({tag, " in_ready in DONE"}, 32'(in_ready), 32'd0);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready after handshake"},  32'(in_ready),  32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int edges;
        issue(v, tag);
        wait_out(edges);
        check_result(v, edges, tag);
        drain(tag);
    endtask

    initial begin
        vec_t v;
        vec_t hold;
        logic [W-1:0] held_out;
        int edges;

        //           a       b       op    out     c  o  s  z  lat
        vecs.push_back(mk(12'hEF1, 12'h000, 3'd0, 12'h10F, 0, 0, 0, 0, 2));
        vecs.push_back(mk(12'h800, 12'h123, 3'd0, 12'h800, 0, 1, 1, 0, 2));
        vecs.push_back(mk(12'h801, 12'h861, 3'd1, 12'h062, 1, 1, 0, 0, 2));
        vecs.push_back(mk(12'h69F, 12'h769, 3'd1, 12'hE08, 0, 1, 1, 0, 2));
        vecs.push_back(mk(12'hFFF, 12'h001, 3'd1, 12'h000, 1, 0, 0, 1, 2));
        vecs.push_back(mk(12'h815, 12'h76B, 3'd6, 12'h0AA, 1, 1, 0, 0, 2));
        vecs.push_back(mk(12'h000, 12'h001, 3'd6, 12'hFFF, 0, 0, 1, 0, 2));
        vecs.push_back(mk(12'hEF1, 12'hE65, 3'd2, 12'hE61, 0, 0, 1, 0, 2));
        vecs.push_back(mk(12'hEF1, 12'hE65, 3'd3, 12'hEF5, 0, 0, 1, 0, 2));
        vecs.push_back(mk(12'hEF1, 12'hE65, 3'd4, 12'h094, 0, 0, 0, 0, 2));
        vecs.push_back(mk(12'hEF1, 12'hE65, 3'd5, 12'h10E, 0, 0, 0, 0, 2));
        vecs.push_back(mk(12'h5A5, 12'h5A5, 3'd4, 12'h000, 0, 0, 0, 1, 2));
`ifdef SEQ_ALU_MUL_EN
        vecs.push_back(mk(12'h012, 12'h00A, 3'd7, 12'h0B4, 0, 0, 0, 0, 13));
        vecs.push_back(mk(12'h100, 12'h010, 3'd7, 12'h000, 0, 1, 0, 1, 13));
        vecs.push_back(mk(12'hFFF, 12'hFFF, 3'd7, 12'h001, 0, 1, 0, 0, 13));
`else
        vecs.push_back(mk(12'h012, 12'h00A, 3'd7, 12'h000, 0, 1, 0, 1, 2));
`endif

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op_select = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset out",       32'(out),       32'd0);
        chk("reset flags",     32'({cout, sign, overflow, zero}), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset busy",      32'(busy),      32'd0);
        chk("reset in_ready",  32'(in_ready),  32'd1);

        foreach (vecs[i]) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: DONE held 5 cycles with a competing in_valid.
        hold = mk(12'h69F, 12'h769, 3'd1, 12'hE08, 0, 1, 1, 0, 2);
        issue(hold, "bp");
        wait_out(edges);
        check_result(hold, edges, "bp");
        held_out = 12'hE08;
        a = 12'h001; b = 12'h001; op_select = 3'd1; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold%0d out", c),       32'(out),       32'(held_out));
            chk($sformatf("bp hold%0d flags", c),     32'({cout, overflow, sign, zero}), 32'b0110);
            chk($sformatf("bp hold%0d out_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp hold%0d in_ready", c),  32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("bp in_ready after release", 32'(in_ready), 32'd1);
        chk("bp busy after release",     32'(busy),     32'd0);
        @(posedge clk); #1;
        chk("bp no accept during DONE", 32'(busy), 32'd0);

        // Reset during an in-flight operation.
`ifdef SEQ_ALU_MUL_EN
        v = mk(12'hFFF, 12'hFFF, 3'd7, 12'h001, 0, 1, 0, 0, 13);
        issue(v, "midrst");
        repeat (5) @(posedge clk);
        #1;
        chk("midrst busy in MUL", 32'(busy), 32'd1);
`else
        v = mk(12'h801, 12'h861, 3'd1, 12'h062, 1, 1, 0, 0, 2);
        issue(v, "midrst");
        chk("midrst busy in EXEC", 32'(busy), 32'd1);
`endif
        void'(exp_q.pop_back());
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst out",       32'(out),       32'd0);
        chk("midrst flags",     32'({cout, sign, overflow, zero}), 32'd0);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst busy",      32'(busy),      32'd0);
        chk("midrst in_ready",  32'(in_ready),  32'd1);

        run_vec(mk(12'h001, 12'h001, 3'd1, 12'h002, 0, 0, 0, 0, 2), "post_rst add");

        chk("scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
